// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - two-requester byte-stream arbiter in front of a UART transmitter
//
// Purpose:
//   Grants the UART byte stream to one of two packet sources at a time.
//   Arbitration is round-robin, and ownership is held until the owner
//   transfers a byte flagged last. Every packet re-arbitrates through IDLE.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   srst_i                synchronous soft reset, overrides every transition
//   req0_*                requester 0 (stdout) val/data/last in, rdy out
//   req1_*                requester 1 (debug/monitor) val/data/last in, rdy out
//   out_val_o/data_o      byte stream to the UART; out_rdy_i is its backpressure
//   avail_i               UART host present; new grants are issued only while high
//   grant_o               one-hot current owner, registered with the state
//   timeout_o             one-cycle pulse when a stalled grant is revoked
//
// Configuration:
//   UART_ARB_TIMEOUT_EN   when defined, a stalled owner loses its grant after
//                         TIMEOUT_CYCLES cycles without a transfer. When not
//                         defined, there is no counter and timeout_o is 0.

module uart_tx_arb #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       srst_i,
    input  logic       req0_val_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_last_i,
    output logic       req0_rdy_o,
    input  logic       req1_val_i,
    input  logic [7:0] req1_data_i,
    input  logic       req1_last_i,
    output logic       req1_rdy_o,
    output logic       out_val_o,
    output logic [7:0] out_data_o,
    input  logic       out_rdy_i,
    input  logic       avail_i,
    output logic [1:0] grant_o,
    output logic       timeout_o
);

    if (TIMEOUT_CYCLES == 16'd0) begin : g_bad_timeout
        $error("uart_tx_arb: TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e     state_q, state_d;
    // Pointer holds the requester served last; it loses the next tie.
    logic       ptr_q, ptr_d;
    logic [1:0] grant_q, grant_d;
    logic       xfer;
    logic       last_sel;
    logic       tmo_hit;
    logic       timeout_d;

    // Data path: the owner is wired straight through to the UART.
    always_comb begin
        out_val_o  = 1'b0;
        out_data_o = 8'h00;
        req0_rdy_o = 1'b0;
        req1_rdy_o = 1'b0;
        last_sel   = 1'b0;
        case (state_q)
            GRANT0: begin
                out_val_o  = req0_val_i;
                out_data_o = req0_data_i;
                req0_rdy_o = out_rdy_i;
                last_sel   = req0_last_i;
            end
            GRANT1: begin
                out_val_o  = req1_val_i;
                out_data_o = req1_data_i;
                req1_rdy_o = out_rdy_i;
                last_sel   = req1_last_i;
            end
            default: begin
                out_val_o  = 1'b0;
                out_data_o = 8'h00;
            end
        endcase
    end

    assign xfer = out_val_o & out_rdy_i;

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q;

    // A transfer in the terminal-count cycle wins over the timeout.
    assign tmo_hit = (state_q != IDLE) && !xfer && (cnt_q == TIMEOUT_CYCLES - 16'd1);

    // Counter is 0 throughout IDLE, so every new grant starts from zero.
    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (srst_i || state_q == IDLE || xfer || tmo_hit) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (avail_i) begin
                    if (req0_val_i && req1_val_i) begin
                        state_d = ptr_q ? GRANT0 : GRANT1;
                    end else if (req0_val_i) begin
                        state_d = GRANT0;
                    end else if (req1_val_i) begin
                        state_d = GRANT1;
                    end
                end
            end
            GRANT0, GRANT1: begin
                if (xfer && last_sel) begin
                    state_d = IDLE;
                    ptr_d   = (state_q == GRANT1);
                end else if (tmo_hit) begin
                    state_d   = IDLE;
                    ptr_d     = (state_q == GRANT1);
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (srst_i) begin
            state_d   = IDLE;
            ptr_d     = 1'b1;
            timeout_d = 1'b0;
        end
        grant_d = {state_d == GRANT1, state_d == GRANT0};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    assign grant_o = grant_q;

endmodule
